// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: shared FSM states, funct3 encodings and store-lane helpers for the memory access unit
package riscv_mem_pkg;

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned TIMEOUT_DEFAULT = 255;

  // Byte-enable pattern for a store of the given width at the given byte offset
  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] off);
    return f3 == F3_B ? 4'b0001 << off : f3 == F3_H ? 4'b0011 << {off[1], 1'b0} : 4'b1111;
  endfunction

  // Narrow store data is replicated across every lane so the strobe alone picks the target bytes
  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
    return f3[1:0] == 2'b00 ? {4{d[7:0]}} : f3[1:0] == 2'b01 ? {2{d[15:0]}} : d;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: selects the addressed lane of a bus read word and sign/zero-extends it
module mem_load_align
  import riscv_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Lane select by byte offset, then extension chosen by width/sign encoding
  always_comb begin
    lane_b = off == 2'd0 ? rdata[7:0] : off == 2'd1 ? rdata[15:8] : off == 2'd2 ? rdata[23:16] : rdata[31:24];
    lane_h = off[1] ? rdata[31:16] : rdata[15:0];
    data = funct3 == F3_B  ? {{24{lane_b[7]}}, lane_b} :
           funct3 == F3_BU ? {24'd0, lane_b} :
           funct3 == F3_H  ? {{16{lane_h[15]}}, lane_h} :
           funct3 == F3_HU ? {16'd0, lane_h} : rdata;
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: stalls the pipeline while a load/store runs over a req/gnt/rvalid bus with timeout
module mem_access_unit
  import riscv_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_en,
  input  logic        mem_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_result,
  input  logic [31:0] Data_B,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state, next_state;
  logic [7:0]  cnt;
  logic [31:0] addr_q, wdata_q, aligned;
  logic [3:0]  wstrb_q;
  logic [2:0]  f3_q;
  logic        we_q, err_q, fault, accept, busy, finish, expire;

  mem_load_align u_align (
    .rdata  (bus_rdata),
    .off    (addr_q[1:0]),
    .funct3 (f3_q),
    .data   (aligned)
  );

  // Decode the incoming access, detect completion/timeout and choose the next state
  always_comb begin
    fault = funct3 == 3'b011 || funct3[2:1] == 2'b11 || (mem_we && funct3[2]) ||
            (funct3[1:0] == 2'b01 && alu_result[0]) || (funct3 == F3_W && alu_result[1:0] != 2'b00);
    accept = state == IDLE && mem_en && !fault;
    busy = state == REQ || state == RESP;
    finish = (state == REQ && bus_gnt && (we_q || bus_rvalid)) || (state == RESP && bus_rvalid);
    expire = busy && !finish && cnt == TO_LAST;
    next_state = accept ? REQ : (finish || expire) ? DONE : (state == REQ && bus_gnt) ? RESP : state == DONE ? IDLE : state;
  end

  // Access state, latched request, wait counter and load result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= 8'd0;
      addr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      f3_q <= '0;
      we_q <= 1'b0;
      err_q <= 1'b0;
      load_data <= '0;
    end else begin
      state <= next_state;
      err_q <= expire;
      cnt <= accept ? 8'd0 : busy ? cnt + 8'd1 : cnt;
      if (accept) begin
        addr_q <= alu_result;
        f3_q <= funct3;
        we_q <= mem_we;
        wstrb_q <= mem_we ? store_strb(funct3, alu_result[1:0]) : 4'b0000;
        wdata_q <= store_data(funct3, Data_B);
      end
      if (finish && !we_q)
        load_data <= aligned;
      else if (expire && !we_q)
        load_data <= '0;
    end
  end

  assign stall = rst_n && (accept || busy);
  assign misaligned = rst_n && state == IDLE && mem_en && fault;
  assign done = state == DONE;
  assign bus_err = err_q;
  assign bus_req = state == REQ;
  assign bus_we = we_q;
  assign bus_addr = {addr_q[31:2], 2'b00};
  assign bus_wdata = wdata_q;
  assign bus_wstrb = wstrb_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed vector table plus reset corner sequences for mem_access_unit
module tb_mem_access_unit;
  import riscv_mem_pkg::*;

  logic        clk, rst_n, mem_en, mem_we, bus_gnt, bus_rvalid;
  logic [2:0]  funct3;
  logic [31:0] alu_result, Data_B, bus_rdata;
  logic        stall, done, misaligned, bus_err, bus_req, bus_we;
  logic [31:0] load_data, bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .mem_en(mem_en), .mem_we(mem_we), .funct3(funct3),
    .alu_result(alu_result), .Data_B(Data_B), .stall(stall), .done(done),
    .load_data(load_data), .misaligned(misaligned), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr, db, rd;
    int          gnt_at, rv_at;
    int          e_mis, e_err, e_done, e_stall, e_req;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata, e_load;
  } vec_t;

  vec_t vecs[15];
  int n_tests = 0, n_fail = 0;
  int n_mis, n_err, n_done, n_stall, n_req;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_strb;
  logic        s_we;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Cycle index 0 is the IDLE cycle presenting the access; gnt/rvalid fire on their listed cycle
  task automatic txn(input vec_t v);
    logic fin;
    fin = 1'b0;
    n_mis = 0; n_err = 0; n_done = 0; n_stall = 0; n_req = 0;
    mem_en = 1'b1; mem_we = v.we; funct3 = v.f3; alu_result = v.addr; Data_B = v.db; bus_rdata = v.rd;
    for (int c = 0; c < 10; c++) begin
      bus_gnt = c == v.gnt_at;
      bus_rvalid = c == v.rv_at;
      #1;
      if (misaligned) n_mis++;
      if (bus_err) n_err++;
      if (done) n_done++;
      if (stall) n_stall++;
      if (bus_req) begin
        n_req++;
        s_addr = bus_addr; s_wdata = bus_wdata; s_strb = bus_wstrb; s_we = bus_we;
      end
      fin = fin || done || misaligned;
      @(posedge clk); #1;
      if (fin) mem_en = 1'b0;
    end
    bus_gnt = 1'b0;
    bus_rvalid = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b0, F3_B,   32'h103, 32'h0,        32'h80FF_FF00,  1,  2, 0, 0, 1, 3, 1, 4'h0, 32'h0,         32'hFFFF_FF80};
    vecs[1]  = '{1'b1, F3_H,   32'h202, 32'h1234_ABCD, 32'h0,         1, -1, 0, 0, 1, 2, 1, 4'hC, 32'hABCD_ABCD, 32'hFFFF_FF80};
    vecs[2]  = '{1'b0, F3_W,   32'h006, 32'h0,        32'h0,         -1, -1, 1, 0, 0, 0, 0, 4'h0, 32'h0,         32'hFFFF_FF80};
    vecs[3]  = '{1'b0, F3_HU,  32'h002, 32'h0,        32'h8000_1111,  1,  1, 0, 0, 1, 2, 1, 4'h0, 32'h0,         32'h0000_8000};
    vecs[4]  = '{1'b1, F3_B,   32'h001, 32'h0000_00A5, 32'h0,         1, -1, 0, 0, 1, 2, 1, 4'h2, 32'hA5A5_A5A5, 32'h0000_8000};
    vecs[5]  = '{1'b1, F3_W,   32'h010, 32'hDEAD_BEEF, 32'h0,         2, -1, 0, 0, 1, 3, 2, 4'hF, 32'hDEAD_BEEF, 32'h0000_8000};
    vecs[6]  = '{1'b0, F3_H,   32'h00A, 32'h0,        32'h8001_7FFE,  1,  3, 0, 0, 1, 4, 1, 4'h0, 32'h0,         32'hFFFF_8001};
    vecs[7]  = '{1'b0, F3_BU,  32'h002, 32'h0,        32'h1280_3456,  1,  1, 0, 0, 1, 2, 1, 4'h0, 32'h0,         32'h0000_0080};
    vecs[8]  = '{1'b1, F3_BU,  32'h000, 32'h0000_00FF, 32'h0,        -1, -1, 1, 0, 0, 0, 0, 4'h0, 32'h0,         32'h0000_0080};
    vecs[9]  = '{1'b0, F3_W,   32'h004, 32'h0,        32'hCAFE_F00D,  1,  1, 0, 0, 1, 2, 1, 4'h0, 32'h0,         32'hCAFE_F00D};
    vecs[10] = '{1'b0, 3'b011, 32'h000, 32'h0,        32'h0,         -1, -1, 1, 0, 0, 0, 0, 4'h0, 32'h0,         32'hCAFE_F00D};
    vecs[11] = '{1'b0, F3_H,   32'h001, 32'h0,        32'h0,         -1, -1, 1, 0, 0, 0, 0, 4'h0, 32'h0,         32'hCAFE_F00D};
    vecs[12] = '{1'b1, F3_W,   32'h000, 32'h0000_0001, 32'h0,        -1, -1, 0, 1, 1, 5, 4, 4'hF, 32'h0000_0001, 32'hCAFE_F00D};
    vecs[13] = '{1'b0, F3_B,   32'h000, 32'h0,        32'h0000_007F,  2,  1, 0, 1, 1, 5, 2, 4'h0, 32'h0,         32'h0000_0000};
    vecs[14] = '{1'b0, F3_W,   32'h00C, 32'h0,        32'h1234_5678,  1,  1, 0, 0, 1, 2, 1, 4'h0, 32'h0,         32'h1234_5678};

    clk = 1'b0; rst_n = 1'b0; mem_en = 1'b1; mem_we = 1'b0; funct3 = F3_W; alu_result = 32'h0;
    Data_B = 32'h0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset stall", 32'(stall), 32'd0);
    chk("reset bus_req", 32'(bus_req), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset bus_err", 32'(bus_err), 32'd0);
    chk("reset load_data", load_data, 32'h0);
    funct3 = 3'b011;
    #1;
    chk("reset misaligned", 32'(misaligned), 32'd0);
    mem_en = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) begin
      txn(vecs[i]);
      chk($sformatf("v%0d misaligned", i), 32'(n_mis), 32'(vecs[i].e_mis));
      chk($sformatf("v%0d bus_err", i), 32'(n_err), 32'(vecs[i].e_err));
      chk($sformatf("v%0d done", i), 32'(n_done), 32'(vecs[i].e_done));
      chk($sformatf("v%0d stall", i), 32'(n_stall), 32'(vecs[i].e_stall));
      chk($sformatf("v%0d bus_req", i), 32'(n_req), 32'(vecs[i].e_req));
      chk($sformatf("v%0d load_data", i), load_data, vecs[i].e_load);
      if (vecs[i].e_req > 0) begin
        chk($sformatf("v%0d bus_addr", i), s_addr, vecs[i].addr & 32'hFFFF_FFFC);
        chk($sformatf("v%0d bus_wstrb", i), 32'(s_strb), 32'(vecs[i].e_strb));
        chk($sformatf("v%0d bus_we", i), 32'(s_we), 32'(vecs[i].we));
        if (vecs[i].we) chk($sformatf("v%0d bus_wdata", i), s_wdata, vecs[i].e_wdata);
      end
    end

    mem_en = 1'b1; mem_we = 1'b0; funct3 = F3_W; alu_result = 32'h40; bus_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    bus_gnt = 1'b1;
    @(posedge clk); #1;
    bus_gnt = 1'b0;
    chk("pre-reset state", 32'(dut.state), 32'(RESP));
    chk("pre-reset stall", 32'(stall), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid reset state", 32'(dut.state), 32'(IDLE));
    chk("mid reset bus_req", 32'(bus_req), 32'd0);
    chk("mid reset stall", 32'(stall), 32'd0);
    chk("mid reset load_data", load_data, 32'h0);
    mem_en = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus_rvalid = 1'b1;
    n_done = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (done) n_done++;
      @(posedge clk); #1;
      bus_rvalid = 1'b0;
    end
    chk("post reset done", 32'(n_done), 32'd0);
    chk("post reset load_data", load_data, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the bus wait-cycle limit per access (1..255).
REQ-002 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  SHALL be the reset: asynchronous, active-low.
REQ-004 mem_en  in  1  SHALL mean the current instruction is a load or store.
REQ-005 mem_we  in  1  SHALL mean store when 1 and load when 0.
REQ-006 funct3  in  3  SHALL give access width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 alu_result  in  32  SHALL be the byte address from the execute stage.
REQ-008 Data_B  in  32  SHALL be the store data (rs2).
REQ-009 stall  out  1  SHALL freeze PC and pipeline inputs while high.
REQ-010 done  out  1  SHALL be a one-cycle completion pulse.
REQ-011 load_data  out  32  SHALL be the extended load result.
REQ-012 misaligned  out  1  SHALL be a one-cycle fault pulse.
REQ-013 bus_err  out  1  SHALL be a one-cycle timeout pulse.
REQ-014 Bus outputs SHALL be bus_req 1, bus_we 1, bus_addr 32, bus_wdata 32, bus_wstrb 4.
REQ-015 Bus inputs SHALL be bus_gnt 1, bus_rvalid 1, bus_rdata 32.

Function
REQ-016 FSM states SHALL be IDLE, REQ, RESP, DONE.
REQ-017 In IDLE, mem_en=1 with a legal, aligned access SHALL latch address/data/strobe, assert stall combinationally in that cycle, and go to REQ.
REQ-018 Fault condition: H/HU with addr[0]=1, W with addr[1:0]!=0, funct3 011/110/111, or a store with funct3 1xx.
REQ-019 On a fault in IDLE: misaligned pulses 1 cycle, no bus access occurs, stall stays 0, state stays IDLE.
REQ-020 In REQ, bus_req SHALL be 1, with bus_addr = {addr[31:2],2'b00} and bus_we, bus_wdata, bus_wstrb held stable until bus_gnt=1.
REQ-021 On a store, bus_gnt SHALL move REQ to DONE.
REQ-022 On a load, bus_gnt SHALL move REQ to RESP; if bus_rvalid=1 in the same cycle, data SHALL be captured and the FSM SHALL go directly to DONE.
REQ-023 In RESP, bus_req SHALL be 0; bus_rvalid SHALL capture bus_rdata and move to DONE.
REQ-024 Store strobes: SB 4'b0001<<addr[1:0]; SH 4'b0011<<{addr[1],1'b0}; SW 4'b1111.
REQ-025 Store data: the byte/halfword SHALL be replicated across all lanes.
REQ-026 Loads: lane selected by addr[1:0]; B/H sign-extended, BU/HU zero-extended, W unchanged.
REQ-027 In DONE: done=1 and stall=0 so the core advances; the next state SHALL be IDLE.
REQ-028 load_data SHALL update only when a load completes and SHALL hold otherwise.
REQ-029 An 8-bit wait counter SHALL clear on entry to REQ and increment each cycle in REQ/RESP.
REQ-030 When the wait counter reaches TIMEOUT_CYCLES, bus_err SHALL pulse, bus_req SHALL drop, load_data SHALL become 0 for loads, and the FSM SHALL go to DONE.
REQ-031 Successive accesses SHALL have a minimum spacing of one IDLE cycle; bus_rvalid arriving in IDLE, REQ or DONE SHALL be ignored.

Reset
REQ-032 On rst_n=0 the FSM SHALL enter IDLE immediately.
REQ-033 During reset, all outputs SHALL be 0, including load_data and bus_req.
REQ-034 Reset mid-access SHALL abandon the transaction with no done pulse.

Structure
REQ-035 Package riscv_mem_pkg SHALL hold the FSM state enum, the funct3 width constants and the TIMEOUT_CYCLES default.
REQ-036 Sub-module mem_load_align SHALL perform combinational lane select and extension.
REQ-037 All other logic SHALL live in mem_access_unit.

Verification
REQ-038 Bench SHALL cover: LB addr 0x103, rdata 0x80FF_FF00, gnt and rvalid 1 cycle later -> load_data 0xFFFF_FF80, done once, stall 3 cycles.
REQ-039 Bench SHALL cover: SH addr 0x202, Data_B 0x1234_ABCD, gnt immediate -> wstrb 4'b1100, wdata 0xABCD_ABCD, bus_addr 0x200.
REQ-040 Bench SHALL cover: LW addr 0x006 -> misaligned pulse, bus_req never 1, stall 0.
REQ-041 Bench SHALL cover: LHU addr 0x002, gnt and rvalid in the same cycle -> load_data 0x0000_8000 from rdata 0x8000_1111, REQ->DONE directly.
REQ-042 Bench SHALL cover: TIMEOUT_CYCLES=4, gnt never asserted -> bus_err at cycle 4, load_data 0, done.
REQ-043 Bench SHALL cover: rst_n low while in RESP -> bus_req 0 and state IDLE immediately, no done pulse.
